// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the two-master sram-like bus arbiter.
//   arb_state_t : transaction FSM state
//   owner_t     : which requester holds the current transaction
//   sram_req_t  : latched request fields driven onto the memory port
package arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } owner_t;

  typedef struct packed {
    logic                    wr;
    logic [ARB_DATA_W/8-1:0] wstrb;
    logic [ARB_ADDR_W-1:0]   addr;
    logic [ARB_DATA_W-1:0]   wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_bus_arbiter_grant.sv
// arb_grant: fixed-priority grant (data over inst) with a bounded-starvation
// counter that forces an inst grant after STARVE_LIMIT consecutive data
// grants taken while inst was waiting.
//   clk, rst     : clock, async active-high reset
//   grant_en     : arbiter is free to grant this cycle
//   inst_req     : instruction-fetch request
//   data_req     : data-access request
//   grant_valid  : a grant happens on the next rising edge
//   grant_owner  : winner of that grant
import arb_pkg::*;

module arb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   grant_en,
  input  logic   inst_req,
  input  logic   data_req,
  output logic   grant_valid,
  output owner_t grant_owner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       inst_wins;

  always_comb begin
    inst_wins   = inst_req && (!data_req || (starve_cnt == LIMIT));
    grant_valid = grant_en && (inst_req || data_req);
    grant_owner = inst_wins ? OWN_INST : OWN_DATA;
  end

  // Only data grants taken over a waiting inst request count toward starvation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_valid) begin
      if (inst_wins) begin
        starve_cnt <= '0;
      end else if (inst_req && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: serialises the inst-fetch and data sram-like ports onto
// one shared memory port, one outstanding transaction at a time.
//   inst_* / data_*   : requester ports (req, wr, wstrb, addr, wdata in;
//                       addr_ok, data_ok pulses and rdata out)
//   mem_*             : shared memory port (req, wr, wstrb, addr, wdata out;
//                       addr_ok, data_ok, rdata in)
//
// state | meaning
// IDLE  | no transaction held; grant on any request
// ADDR  | request latched, mem_req high, waiting for mem_addr_ok
// RESP  | address accepted, waiting for mem_data_ok
import arb_pkg::*;

module sram_bus_arbiter #(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state_q, state_d;
  owner_t     owner_q;
  sram_req_t  req_q, req_sel;
  logic       grant_valid;
  owner_t     grant_owner;
  logic       addr_hs, data_hs, resp_inst, resp_data;

  arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clk         (clk),
    .rst         (rst),
    .grant_en    (state_q == IDLE),
    .inst_req    (inst_req),
    .data_req    (data_req),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    req_sel = (grant_owner == OWN_INST)
              ? '{wr: inst_wr, wstrb: inst_wstrb, addr: inst_addr, wdata: inst_wdata}
              : '{wr: data_wr, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};
  end

  // A mem_data_ok outside RESP is ignored, including one coincident with
  // mem_addr_ok in ADDR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ADDR;
      ADDR:    if (mem_addr_ok) state_d = RESP;
      RESP:    if (mem_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_INST;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        owner_q <= grant_owner;
        req_q   <= req_sel;
      end
    end
  end

  // Memory request fields come only from the latch so requesters may move on
  // after their addr_ok.
  always_comb begin
    mem_req      = (state_q == ADDR);
    mem_wr       = req_q.wr;
    mem_wstrb    = req_q.wstrb;
    mem_addr     = req_q.addr;
    mem_wdata    = req_q.wdata;

    addr_hs      = (state_q == ADDR) && mem_addr_ok;
    data_hs      = (state_q == RESP) && mem_data_ok;
    resp_inst    = (state_q == RESP) && (owner_q == OWN_INST);
    resp_data    = (state_q == RESP) && (owner_q == OWN_DATA);

    inst_addr_ok = addr_hs && (owner_q == OWN_INST);
    data_addr_ok = addr_hs && (owner_q == OWN_DATA);
    inst_data_ok = data_hs && (owner_q == OWN_INST);
    data_data_ok = data_hs && (owner_q == OWN_DATA);
    inst_rdata   = resp_inst ? mem_rdata : '0;
    data_rdata   = resp_data ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [3:0] inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0] data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) u_dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  typedef struct {
    bit          ireq, dreq, dwr;
    logic [31:0] iaddr, daddr, dwdata, rdata;
    bit          exp_inst;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  // random-phase model state
  int          ph, nph, s_model;
  bit          ipend, dpend, own_inst;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic        e_wr;

  initial begin
    int n_gr, bad_addr, bad_req, n_dok, n_iok, n_aok;
    bit resp_pend;
    bit gseq[5];

    // reset state, with memory acks forced high to prove gating
    rst = 1;
    clear_inputs();
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    check("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", {inst_rdata, data_rdata}, 0);
    @(posedge clk); #1;
    rst = 0;
    clear_inputs();

    vecs[0] = '{1, 0, 0, 32'hBFC0_0000, 32'h0,         32'h0,         32'h1234_5678, 1, 32'hBFC0_0000};
    vecs[1] = '{0, 1, 0, 32'h0,         32'h0000_2000, 32'h0,         32'hA5A5_0001, 0, 32'h0000_2000};
    vecs[2] = '{1, 1, 0, 32'hBFC0_0004, 32'h0000_3000, 32'h0,         32'h0BAD_CAFE, 0, 32'h0000_3000};
    vecs[3] = '{1, 1, 1, 32'hBFC0_0008, 32'h0000_3004, 32'hCAFE_F00D, 32'h0,         0, 32'h0000_3004};
    vecs[4] = '{1, 0, 0, 32'hBFC0_000C, 32'h0,         32'h0,         32'h7777_0000, 1, 32'hBFC0_000C};
    vecs[5] = '{0, 1, 1, 32'h0,         32'h0000_4000, 32'h1357_9BDF, 32'h0,         0, 32'h0000_4000};

    for (int i = 0; i < 6; i++) begin
      inst_req = vecs[i].ireq; inst_addr = vecs[i].iaddr;
      data_req = vecs[i].dreq; data_addr = vecs[i].daddr;
      data_wr = vecs[i].dwr; data_wdata = vecs[i].dwdata; data_wstrb = 4'hF;
      mem_addr_ok = 1;
      tick();
      @(negedge clk);
      check("vec_mem_req", mem_req, 1);
      check("vec_mem_addr", mem_addr, vecs[i].exp_addr);
      check("vec_mem_wr", mem_wr, vecs[i].exp_inst ? 1'b0 : vecs[i].dwr);
      check("vec_mem_wdata", mem_wdata, vecs[i].exp_inst ? 32'h0 : vecs[i].dwdata);
      check("vec_addr_ok", {inst_addr_ok, data_addr_ok}, {vecs[i].exp_inst, !vecs[i].exp_inst});
      tick();
      inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = vecs[i].rdata;
      @(negedge clk);
      check("vec_mem_req_resp", mem_req, 0);
      check("vec_data_ok", {inst_data_ok, data_data_ok}, {vecs[i].exp_inst, !vecs[i].exp_inst});
      check("vec_inst_rdata", inst_rdata, vecs[i].exp_inst ? vecs[i].rdata : 32'h0);
      check("vec_data_rdata", data_rdata, vecs[i].exp_inst ? 32'h0 : vecs[i].rdata);
      tick();
      mem_data_ok = 0;
    end

    // simultaneous requests: data write first, then inst read
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC0_0100;
    data_req = 1; data_wr = 1; data_addr = 32'h0000_1000; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    mem_addr_ok = 1;
    tick();
    @(negedge clk);
    check("sim_first_addr", mem_addr, 32'h0000_1000);
    check("sim_first_wr", {mem_wr, mem_wstrb}, {1'b1, 4'hF});
    check("sim_first_owner", {inst_addr_ok, data_addr_ok}, 2'b01);
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    check("sim_first_dok", {inst_data_ok, data_data_ok}, 2'b01);
    tick();
    mem_data_ok = 0; mem_addr_ok = 1;
    tick();
    @(negedge clk);
    check("sim_second_addr", mem_addr, 32'hBFC0_0100);
    check("sim_second_wr", mem_wr, 0);
    check("sim_second_owner", {inst_addr_ok, data_addr_ok}, 2'b10);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_0011;
    @(negedge clk);
    check("sim_second_dok", {inst_data_ok, data_data_ok}, 2'b10);
    check("sim_second_rdata", inst_rdata, 32'h0000_0011);
    tick();
    mem_data_ok = 0;

    // starvation bound: 4 data grants then one inst grant
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC0_0200;
    data_req = 1; data_addr = 32'h0000_5000;
    n_gr = 0; resp_pend = 0;
    for (int c = 0; c < 40 && n_gr < 5; c++) begin
      mem_addr_ok = mem_req;
      mem_data_ok = resp_pend;
      @(negedge clk);
      resp_pend = mem_req && mem_addr_ok;
      if (inst_addr_ok || data_addr_ok) begin
        gseq[n_gr] = inst_addr_ok;
        n_gr++;
      end
      @(posedge clk); #1;
      if (n_gr > 0 && gseq[n_gr-1]) inst_req = 0;
    end
    check("starve_grant_count", n_gr, 5);
    for (int i = 0; i < 5; i++) check($sformatf("starve_grant_%0d", i), gseq[i], (i == 4));
    check("starve_cnt_cleared", u_dut.u_grant.starve_cnt, 0);

    // slow memory: addr_ok on 3rd ADDR cycle, data_ok on 5th RESP cycle
    do_reset();
    data_req = 1; data_addr = 32'h2222_0000;
    tick();
    bad_addr = 0; bad_req = 0; n_dok = 0; n_iok = 0; n_aok = 0;
    for (int c = 0; c < 12; c++) begin
      mem_addr_ok = (c == 2);
      mem_data_ok = (c == 7);
      mem_rdata = 32'h600D_0000 + 32'(c);
      if (c == 3) begin data_addr = 32'h5555_5555; data_req = 0; end
      @(negedge clk);
      if (mem_addr !== 32'h2222_0000) bad_addr++;
      if (mem_req !== (c <= 2)) bad_req++;
      if (data_addr_ok) n_aok++;
      if (inst_data_ok || inst_addr_ok) n_iok++;
      if (data_data_ok) begin
        n_dok++;
        check("slow_rdata", data_rdata, 32'h600D_0007);
      end
      tick();
    end
    check("slow_addr_stable", bad_addr, 0);
    check("slow_mem_req", bad_req, 0);
    check("slow_addr_ok_count", n_aok, 1);
    check("slow_data_ok_count", n_dok, 1);
    check("slow_inst_pulses", n_iok, 0);

    // reset asserted during RESP
    do_reset();
    inst_req = 1; inst_addr = 32'h8000_0000; mem_addr_ok = 1;
    tick();
    tick();
    inst_req = 0; mem_addr_ok = 0;
    #2;
    rst = 1; mem_data_ok = 1; mem_rdata = 32'hAAAA_5555;
    #1;
    check("rst_resp_mem_req", mem_req, 0);
    check("rst_resp_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    check("rst_resp_rdata", {inst_rdata, data_rdata}, 0);
    check("rst_resp_addr", mem_addr, 0);
    tick();
    rst = 0;
    n_dok = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (inst_data_ok || data_data_ok) n_dok++;
      tick();
    end
    check("rst_resp_no_dok", n_dok, 0);
    mem_data_ok = 0; data_req = 1; data_addr = 32'h0000_6000;
    @(negedge clk);
    check("rst_resp_idle", mem_req, 0);
    tick();
    @(negedge clk);
    check("rst_resp_new_req", {mem_req, mem_addr}, {1'b1, 32'h0000_6000});

    // spurious mem_data_ok in IDLE
    do_reset();
    mem_data_ok = 1;
    n_dok = 0; bad_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (inst_data_ok || data_data_ok) n_dok++;
      if (mem_req !== 1'b0) bad_req++;
      tick();
    end
    check("spur_no_dok", n_dok, 0);
    check("spur_no_req", bad_req, 0);
    mem_data_ok = 0; inst_req = 1; inst_addr = 32'h0000_0040;
    tick();
    @(negedge clk);
    check("spur_then_grant", {mem_req, mem_addr}, {1'b1, 32'h0000_0040});

    // randomized traffic against a transaction-level model
    do_reset();
    ph = 0; s_model = 0; ipend = 0; dpend = 0; own_inst = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!ipend && $urandom_range(0, 3) == 0) begin
        ipend = 1; inst_addr = $urandom; inst_wr = 0; inst_wstrb = 0; inst_wdata = 0;
      end
      inst_req = ipend;
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1; data_addr = $urandom; data_wr = 1'($urandom_range(0, 1));
        data_wstrb = 4'($urandom_range(0, 15)); data_wdata = $urandom;
      end
      data_req = dpend;
      mem_rdata = $urandom;
      mem_addr_ok = (ph == 1) && ($urandom_range(0, 2) == 0);
      mem_data_ok = (ph == 2) ? ($urandom_range(0, 2) == 0)
                              : (!mem_addr_ok && $urandom_range(0, 4) == 0);
      @(negedge clk);
      nph = ph;
      check("rnd_mem_req", mem_req, (ph == 1));
      if (ph == 1 && mem_addr_ok) begin
        check("rnd_addr", mem_addr, e_addr);
        check("rnd_fields", {mem_wr, mem_wstrb, mem_wdata}, {e_wr, e_wstrb, e_wdata});
        check("rnd_addr_ok", {inst_addr_ok, data_addr_ok}, {own_inst, !own_inst});
        if (own_inst) ipend = 0; else dpend = 0;
        nph = 2;
      end else begin
        check("rnd_no_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
      end
      if (ph == 2 && mem_data_ok) begin
        check("rnd_data_ok", {inst_data_ok, data_data_ok}, {own_inst, !own_inst});
        if (!e_wr) check("rnd_rdata", {inst_rdata, data_rdata},
                         own_inst ? {mem_rdata, 32'h0} : {32'h0, mem_rdata});
        nph = 0;
      end else begin
        check("rnd_no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      end
      if (ph == 0 && (inst_req || data_req)) begin
        own_inst = inst_req && (!data_req || s_model == STARVE_LIMIT);
        if (own_inst) begin
          e_addr = inst_addr; e_wr = inst_wr; e_wstrb = inst_wstrb; e_wdata = inst_wdata;
          s_model = 0;
        end else begin
          e_addr = data_addr; e_wr = data_wr; e_wstrb = data_wstrb; e_wdata = data_wdata;
          if (inst_req && s_model < STARVE_LIMIT) s_model++;
        end
        nph = 1;
      end
      ph = nph;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
